// File: rtl/aes_enc_iter.sv
// Iterative AES-128/192/256 encryption core: one round per clock, on-the-fly key expansion.
// Build option AES_ZEROIZE_EN clears round state, key window and ciphertext after the output handshake.
module aes_enc_iter #(
    parameter int unsigned KEY_BITS = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KEY_BITS-1:0] key,
    input  logic [127:0]        plaintext,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [127:0]        ciphertext,
    output logic                busy
);
    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = NK + 6;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_enc_iter: KEY_BITS must be 128, 192 or 256");
    end

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} fsm_t;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [10:0] base;
        base = {~x, 3'b000};
        return SBOX[base +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // SubBytes followed by ShiftRows; byte k of the block lives at a[15-k].
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [15:0][7:0] a;
        logic [15:0][7:0] b;
        a = s;
        b = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b[4'(15 - 4*c - r)] = sbox(a[4'(15 - 4*((c + r) % 4) - r)]);
            end
        end
        return b;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [15:0][7:0] a;
        logic [15:0][7:0] b;
        logic [7:0] a0, a1, a2, a3;
        a = s;
        b = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = a[4'(15 - 4*c)];
            a1 = a[4'(14 - 4*c)];
            a2 = a[4'(13 - 4*c)];
            a3 = a[4'(12 - 4*c)];
            b[4'(15 - 4*c)] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            b[4'(14 - 4*c)] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            b[4'(13 - 4*c)] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            b[4'(12 - 4*c)] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return b;
    endfunction

    fsm_t         fsm;
    logic [127:0] st;
    logic [31:0]  win [NK];
    logic [3:0]   round;
    logic [2:0]   gmod;
    logic [7:0]   rcon;

    logic         accept;
    logic         last_round;
    logic [31:0]  cw [NK+4];
    logic [31:0]  win_nx [NK];
    logic [31:0]  ld_win [NK];
    logic [127:0] ld_state;
    logic [127:0] rk;
    logic [127:0] ss;
    logic [127:0] round_out;
    logic [31:0]  prev;
    logic [31:0]  tmp;
    logic [3:0]   idx;
    logic [3:0]   g4;
    logic [2:0]   gmod_nx;
    logic         rcon_hit;
    logic [7:0]   rcon_nx;

    assign in_ready   = (fsm == S_IDLE) | ((fsm == S_DONE) & out_ready);
    assign accept     = in_valid & in_ready;
    assign last_round = (round == 4'(NR));
    assign ld_state   = plaintext ^ key[KEY_BITS-1 -: 128];

    always_comb begin
        for (int k = 0; k < NK; k++) begin
            ld_win[k] = key[KEY_BITS-1-32*k -: 32];
        end
    end

    // Window holds the last NK expanded words; cw appends the 4 words generated this cycle.
    // The round key always sits at cw[4..7] because generation runs NK-4 words ahead.
    always_comb begin
        rcon_hit = 1'b0;
        idx      = '0;
        tmp      = '0;
        for (int k = 0; k < NK; k++) begin
            cw[k] = win[k];
        end
        prev = cw[NK-1];
        for (int j = 0; j < 4; j++) begin
            idx = 4'(gmod) + 4'(j);
            if (idx >= 4'(NK)) begin
                idx = idx - 4'(NK);
            end
            if (idx == 4'd0) begin
                tmp      = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
                rcon_hit = 1'b1;
            end else if (NK == 8 && idx == 4'd4) begin
                tmp = sub_word(prev);
            end else begin
                tmp = prev;
            end
            cw[NK+j] = cw[j] ^ tmp;
            prev     = cw[NK+j];
        end
        for (int k = 0; k < NK; k++) begin
            win_nx[k] = cw[k+4];
        end
        rk = {cw[4], cw[5], cw[6], cw[7]};
        g4 = 4'(gmod) + 4'd4;
        if (g4 >= 4'(NK)) begin
            g4 = g4 - 4'(NK);
        end
        gmod_nx = g4[2:0];
        rcon_nx = rcon_hit ? xtime(rcon) : rcon;
    end

    always_comb begin
        ss        = sub_shift(st);
        round_out = last_round ? (ss ^ rk) : (mix_columns(ss) ^ rk);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm        <= S_IDLE;
            st         <= '0;
            for (int k = 0; k < NK; k++) win[k] <= '0;
            round      <= '0;
            gmod       <= '0;
            rcon       <= 8'h01;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            ciphertext <= '0;
        end else if (accept) begin
            fsm       <= S_RUN;
            st        <= ld_state;
            for (int k = 0; k < NK; k++) win[k] <= ld_win[k];
            round     <= 4'd1;
            gmod      <= '0;
            rcon      <= 8'h01;
            out_valid <= 1'b0;
            busy      <= 1'b1;
`ifdef AES_ZEROIZE_EN
            ciphertext <= '0;
`endif
        end else begin
            unique case (fsm)
                S_RUN: begin
                    st   <= round_out;
                    for (int k = 0; k < NK; k++) win[k] <= win_nx[k];
                    gmod <= gmod_nx;
                    rcon <= rcon_nx;
                    if (last_round) begin
                        ciphertext <= round_out;
                        out_valid  <= 1'b1;
                        busy       <= 1'b0;
                        fsm        <= S_DONE;
                    end else begin
                        round <= round + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        fsm       <= S_IDLE;
`ifdef AES_ZEROIZE_EN
                        ciphertext <= '0;
                        st         <= '0;
                        for (int k = 0; k < NK; k++) win[k] <= '0;
`endif
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed FIPS-197 vector bench for aes_enc_iter at 128/192/256-bit keys.
// Ciphertext expectation after the output handshake follows AES_ZEROIZE_EN.
module tb_aes_enc_iter;
    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] E1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] E2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [191:0] K3 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] E3 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] K4 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] E4 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         iv, ir, ov, ordy, bz;
    logic [127:0] k128, pt, ct;
    logic         iv2, ir2, ov2, bz2;
    logic [191:0] k192;
    logic [127:0] ct2;
    logic         iv3, ir3, ov3, bz3;
    logic [255:0] k256;
    logic [127:0] ct3;

    aes_enc_iter #(.KEY_BITS(128)) dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .key(k128), .plaintext(pt),
        .out_valid(ov), .out_ready(ordy), .ciphertext(ct), .busy(bz));
    aes_enc_iter #(.KEY_BITS(192)) dut192 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .key(k192), .plaintext(P1),
        .out_valid(ov2), .out_ready(1'b1), .ciphertext(ct2), .busy(bz2));
    aes_enc_iter #(.KEY_BITS(256)) dut256 (
        .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .key(k256), .plaintext(P1),
        .out_valid(ov3), .out_ready(1'b1), .ciphertext(ct3), .busy(bz3));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_q[$];
    logic [127:0] out_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Records every accept and output handshake seen by the 128-bit core.
    always @(posedge clk) begin
        if (!rst) begin
            if (iv && ir) acc_q.push_back(cyc);
            if (ov && ordy) out_q.push_back(ct);
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one block from IDLE with out_ready high and checks latency, busy length and result.
    task automatic run_one(input string tag, input logic [127:0] k, input logic [127:0] p,
                           input logic [127:0] e);
        int n;
        int bc;
        check({tag, "_ir"}, 128'(ir), 128'd1);
        ordy = 1'b1; k128 = k; pt = p; iv = 1'b1;
        tick();
        iv = 1'b0;
        n = 1; bc = 0;
        while (!ov && n < 40) begin
            if (bz) bc++;
            tick();
            n++;
        end
        check({tag, "_lat"}, 128'(n), 128'd11);
        check({tag, "_busy"}, 128'(bc), 128'd10);
        check({tag, "_ct"}, ct, e);
        tick();
        check({tag, "_ov_clr"}, 128'(ov), 128'd0);
    endtask

    initial begin
        int n;
        int a0;
        logic ok;
        rst = 1'b1; iv = 1'b0; ordy = 1'b1; k128 = '0; pt = '0;
        iv2 = 1'b0; k192 = '0; iv3 = 1'b0; k256 = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_ir", 128'(ir), 128'd1);
        check("rst_ov", 128'(ov), 128'd0);
        check("rst_busy", 128'(bz), 128'd0);
        check("rst_ct", ct, 128'd0);

        run_one("v128a", K1, P1, E1);
        run_one("v128b", K2, P2, E2);

        k192 = K3; iv2 = 1'b1;
        tick();
        iv2 = 1'b0;
        n = 1;
        while (!ov2 && n < 40) begin tick(); n++; end
        check("v192_lat", 128'(n), 128'd13);
        check("v192_ct", ct2, E3);

        k256 = K4; iv3 = 1'b1;
        tick();
        iv3 = 1'b0;
        n = 1;
        while (!ov3 && n < 40) begin tick(); n++; end
        check("v256_lat", 128'(n), 128'd15);
        check("v256_ct", ct3, E4);
        tick();

        // Back-to-back: in_valid held high, second block taken in the DONE cycle.
        acc_q.delete(); out_q.delete();
        ordy = 1'b1; k128 = K1; pt = P1; iv = 1'b1;
        tick();
        k128 = K2; pt = P2;
        n = 0;
        while (acc_q.size() < 2 && n < 40) begin tick(); n++; end
        iv = 1'b0;
        n = 0;
        while (out_q.size() < 2 && n < 40) begin tick(); n++; end
        check("b2b_acc_n", 128'(acc_q.size()), 128'd2);
        check("b2b_out_n", 128'(out_q.size()), 128'd2);
        if (acc_q.size() >= 2) check("b2b_gap", 128'(acc_q[1] - acc_q[0]), 128'd11);
        if (out_q.size() >= 2) begin
            check("b2b_ct0", out_q[0], E1);
            check("b2b_ct1", out_q[1], E2);
        end
        tick();

        // Output stall: result and out_valid hold, no accept while out_ready is low.
        a0 = acc_q.size();
        ordy = 1'b0; k128 = K1; pt = P1; iv = 1'b1;
        tick();
        iv = 1'b0;
        n = 1;
        while (!ov && n < 40) begin tick(); n++; end
        check("hold_lat", 128'(n), 128'd11);
        iv = 1'b1; k128 = K2; pt = P2;
        ok = 1'b1;
        repeat (20) begin
            tick();
            if (!(ov === 1'b1 && ct === E1 && ir === 1'b0)) ok = 1'b0;
        end
        check("hold_stable", 128'(ok), 128'd1);
        check("hold_ir", 128'(ir), 128'd0);
        check("hold_acc", 128'(acc_q.size() - a0), 128'd1);
        iv = 1'b0; ordy = 1'b1;
        tick();
        check("post_hs_ov", 128'(ov), 128'd0);
`ifdef AES_ZEROIZE_EN
        check("post_hs_ct", ct, 128'd0);
`else
        check("post_hs_ct", ct, E1);
`endif

        // Input changes and in_valid pulses during RUN are ignored.
        a0 = acc_q.size();
        k128 = K2; pt = P2; iv = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            k128 = {$urandom(), $urandom(), $urandom(), $urandom()};
            pt   = {$urandom(), $urandom(), $urandom(), $urandom()};
            iv   = i[0];
            tick();
        end
        iv = 1'b0;
        n = 7;
        while (!ov && n < 40) begin tick(); n++; end
        check("inj_lat", 128'(n), 128'd11);
        check("inj_ct", ct, E2);
        check("inj_acc", 128'(acc_q.size() - a0), 128'd1);
        tick();

        // Reset in the middle of a block discards it.
        k128 = K1; pt = P1; iv = 1'b1;
        tick();
        iv = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_ir", 128'(ir), 128'd1);
        check("mid_rst_ov", 128'(ov), 128'd0);
        check("mid_rst_ct", ct, 128'd0);
        tick();
        rst = 1'b0;
        ok = 1'b0;
        repeat (15) begin
            tick();
            if (ov) ok = 1'b1;
        end
        check("mid_rst_no_ov", 128'(ok), 128'd0);
        check("mid_rst_ct_hold", ct, 128'd0);
        run_one("after_rst", K2, P2, E2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
